// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: widths, instruction classes, ALU op codes,
// flag bit positions and the sequencer state encoding.
package alu_sequencer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_NUM_REGS   = 16;
    localparam int REG_ADDR_W         = 4;

    localparam logic [3:0] CLASS_ALU = 4'b0001;
    localparam logic [3:0] CLASS_IMM = 4'b0010;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8
    } alu_op_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_O = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus ALU operand/result bus. master = fetch path and ALU,
// slave = sequencer.
interface alu_sequencer_if
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [15:0]           instr_op;
    logic [11:0]           instr_addr;
    logic [15:0]           alu_opcode;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_c;
    logic [3:0]            alu_flags;

    modport master (
        output instr_valid, instr_op, instr_addr, alu_c, alu_flags,
        input  instr_ready, alu_opcode, alu_a, alu_b
    );

    modport slave (
        input  instr_valid, instr_op, instr_addr, alu_c, alu_flags,
        output instr_ready, alu_opcode, alu_a, alu_b
    );
endinterface

// File: rtl/alu_seq_regfile.sv
// Register file: two combinational read ports, a debug read port and one
// synchronous write port; asynchronous reset clears every entry.
module alu_seq_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    logic [DATA_WIDTH-1:0] rf [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = rf[rd_addr_a];
    assign rd_data_b = rf[rd_addr_b];
    assign dbg_data  = rf[dbg_addr];
endmodule

// File: rtl/alu_sequencer.sv
// ALU issue sequencer: IDLE -> READ -> EXEC -> WB, one instruction per four cycles.
// Define ALU_SEQ_IMMEDIATE_EN to execute class 4'b0010 as an immediate ALU op.
//   state  | meaning
//   S_IDLE | ready for an instruction; external register loads allowed
//   S_READ | register operands and opcode towards the ALU
//   S_EXEC | ALU inputs stable; capture result and flags
//   S_WB   | write result/flags for ALU classes; pulse done next cycle
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_sequencer_if.slave        bus,
    output logic                  done,
    output logic [3:0]            flags,
    input  logic                  ext_wr_en,
    input  logic [REG_ADDR_W-1:0] ext_wr_addr,
    input  logic [DATA_WIDTH-1:0] ext_wr_data,
    input  logic [REG_ADDR_W-1:0] dbg_rd_addr,
    output logic [DATA_WIDTH-1:0] dbg_rd_data
);
    seq_state_t state_q, state_d;

    logic [15:0]           op_q;
    logic [11:0]           addr_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [3:0]            flags_q;
    logic                  is_imm, does_wb;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata, rd_a, rd_b;

`ifdef ALU_SEQ_IMMEDIATE_EN
    assign is_imm = (op_q[15:12] == CLASS_IMM);
`else
    assign is_imm = 1'b0;
`endif
    assign does_wb = (op_q[15:12] == CLASS_ALU) || is_imm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.instr_ready = 1'b0;
        rf_we           = 1'b0;
        rf_waddr        = ext_wr_addr;
        rf_wdata        = ext_wr_data;
        case (state_q)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                rf_we           = ext_wr_en;
                if (bus.instr_valid) state_d = S_READ;
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB: begin
                state_d = S_IDLE;
                if (does_wb) begin
                    rf_we    = 1'b1;
                    rf_waddr = addr_q[11:8];
                    rf_wdata = result_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q           <= '0;
            addr_q         <= '0;
            result_q       <= '0;
            flags_q        <= '0;
            bus.alu_opcode <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            flags          <= 4'b0001;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        op_q   <= bus.instr_op;
                        addr_q <= bus.instr_addr;
                    end
                end
                S_READ: begin
                    // immediate ops reach the ALU as ordinary ALU-class opcodes
                    bus.alu_opcode <= is_imm ? {CLASS_ALU, op_q[11:0]} : op_q;
                    bus.alu_a      <= rd_a;
                    bus.alu_b      <= is_imm ? {{(DATA_WIDTH-4){1'b0}}, addr_q[3:0]} : rd_b;
                end
                S_EXEC: begin
                    result_q <= bus.alu_c;
                    flags_q  <= bus.alu_flags;
                end
                S_WB: begin
                    if (does_wb) flags <= flags_q;
                    done           <= 1'b1;
                    bus.alu_opcode <= '0;
                end
                default: ;
            endcase
        end
    end

    alu_seq_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_W     (REG_ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (rf_we),
        .wr_addr   (rf_waddr),
        .wr_data   (rf_wdata),
        .rd_addr_a (addr_q[7:4]),
        .rd_data_a (rd_a),
        .rd_addr_b (addr_q[3:0]),
        .rd_data_b (rd_b),
        .dbg_addr  (dbg_rd_addr),
        .dbg_data  (dbg_rd_data)
    );
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small combinational ALU behind the bus.
// Immediate-op expectations follow ALU_SEQ_IMMEDIATE_EN.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        done;
    logic [3:0]  flags;
    logic        ext_wr_en;
    logic [3:0]  ext_wr_addr;
    logic [15:0] ext_wr_data;
    logic [3:0]  dbg_rd_addr;
    logic [15:0] dbg_rd_data;

    int n_vec  = 0;
    int n_miss = 0;

    alu_sequencer_if #(.DATA_WIDTH(16)) bus ();

    alu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .done        (done),
        .flags       (flags),
        .ext_wr_en   (ext_wr_en),
        .ext_wr_addr (ext_wr_addr),
        .ext_wr_data (ext_wr_data),
        .dbg_rd_addr (dbg_rd_addr),
        .dbg_rd_data (dbg_rd_data)
    );

    always #5 clk = ~clk;

    logic [16:0] wide;
    logic        ovf;
    always_comb begin
        wide = '0;
        ovf  = 1'b0;
        case (bus.alu_opcode[11:8])
            4'h0: begin
                wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                ovf  = (bus.alu_a[15] == bus.alu_b[15]) && (wide[15] != bus.alu_a[15]);
            end
            4'h1: begin
                wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                ovf  = (bus.alu_a[15] != bus.alu_b[15]) && (wide[15] != bus.alu_a[15]);
            end
            4'h2: wide = {1'b0, bus.alu_a & bus.alu_b};
            4'h3: wide = {1'b0, bus.alu_a | bus.alu_b};
            4'h4: wide = {1'b0, bus.alu_a ^ bus.alu_b};
            default: wide = '0;
        endcase
        bus.alu_c     = wide[15:0];
        bus.alu_flags = {ovf, wide[15], wide[16], (wide[15:0] == 16'h0)};
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        dbg_rd_addr = addr;
        #1;
        check_val(tag, {16'h0, dbg_rd_data}, {16'h0, exp});
    endtask

    task automatic ext_load(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        ext_wr_en   = 1'b1;
        ext_wr_addr = addr;
        ext_wr_data = data;
        @(negedge clk);
        ext_wr_en = 1'b0;
    endtask

    // Offers one instruction, waits for acceptance, then samples #1 after each edge
    // until done. lat counts edges after the accept edge; low counts not-ready samples.
    task automatic run_instr(input logic [15:0] op, input logic [11:0] addr,
                             output int lat, output int low,
                             output logic [15:0] a_s, output logic [15:0] b_s);
        bit got = 1'b0;
        lat = -1;
        low = 0;
        a_s = '0;
        b_s = '0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_addr  = addr;
        for (int i = 0; i < 10; i++) begin
            if (bus.instr_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check_val("accept_timeout", 0, 1);
            bus.instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!bus.instr_ready) low++;
            if (k == 1) begin
                a_s = bus.alu_a;
                b_s = bus.alu_b;
            end
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    int          lat, low, dn;
    logic [15:0] a_s, b_s;

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b1;
        ext_wr_en       = 1'b0;
        ext_wr_addr     = '0;
        ext_wr_data     = '0;
        dbg_rd_addr     = '0;
        bus.instr_valid = 1'b0;
        bus.instr_op    = '0;
        bus.instr_addr  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check_val("rst_ready", {31'h0, bus.instr_ready}, 1);
        check_val("rst_flags", {28'h0, flags}, 4'b0001);
        check_val("rst_done", {31'h0, done}, 0);
        check_val("rst_opcode", {16'h0, bus.alu_opcode}, 0);
        check_reg("rst_r3", 4'd3, 16'h0);

        // ADD R3 = R1 + R2
        ext_load(4'd1, 16'd5);
        ext_load(4'd2, 16'd3);
        check_reg("load_r1", 4'd1, 16'd5);
        run_instr(16'h1000, 12'h312, lat, low, a_s, b_s);
        check_val("add_alu_a", {16'h0, a_s}, 5);
        check_val("add_alu_b", {16'h0, b_s}, 3);
        check_val("add_latency", lat, 3);
        check_reg("add_r3", 4'd3, 16'd8);
        check_val("add_flags", {28'h0, flags}, 4'b0000);
        @(posedge clk); #1;
        check_val("done_one_cycle", {31'h0, done}, 0);
        check_val("opcode_cleared", {16'h0, bus.alu_opcode}, 0);

        // SUB R4 = R1 - R2 = 0
        ext_load(4'd1, 16'd3);
        ext_load(4'd2, 16'd3);
        run_instr(16'h1100, 12'h412, lat, low, a_s, b_s);
        check_reg("sub_r4", 4'd4, 16'd0);
        check_val("sub_flags", {28'h0, flags}, 4'b0001);

        // ADD 8000+8000 sets O,C,Z; then a class-0 SUB must not write or touch flags
        ext_load(4'd1, 16'h8000);
        ext_load(4'd2, 16'h8000);
        ext_load(4'd7, 16'h1234);
        run_instr(16'h1000, 12'h612, lat, low, a_s, b_s);
        check_reg("ovf_r6", 4'd6, 16'h0);
        check_val("ovf_flags", {28'h0, flags}, 4'b1011);
        run_instr(16'h0100, 12'h712, lat, low, a_s, b_s);
        check_val("nonalu_latency", lat, 3);
        check_val("nonalu_ready_low", low, 3);
        check_reg("nonalu_r7", 4'd7, 16'h1234);
        check_val("nonalu_flags", {28'h0, flags}, 4'b1011);

        // back-to-back dependent: R3 = R1+R2, then R3 = R3+R3 with valid held
        ext_load(4'd1, 16'd5);
        ext_load(4'd2, 16'd3);
        ext_load(4'd3, 16'h0100);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 16'h1000;
        bus.instr_addr  = 12'h312;
        @(posedge clk); #1;
        bus.instr_addr = 12'h333;
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("b2b_first_latency", lat, 3);
        check_val("b2b_ready_at_done", {31'h0, bus.instr_ready}, 1);
        check_reg("b2b_first_r3", 4'd3, 16'd8);
        @(posedge clk); #1;
        check_val("b2b_second_accepted", {31'h0, bus.instr_ready}, 0);
        bus.instr_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("b2b_second_latency", lat, 3);
        check_reg("b2b_r3", 4'd3, 16'd16);

        // reset during EXEC aborts the instruction
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 16'h1000;
        bus.instr_addr  = 12'h812;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        check_val("exec_opcode", {16'h0, bus.alu_opcode}, 16'h1000);
        reset = 1'b1;
        #1;
        check_val("abort_ready", {31'h0, bus.instr_ready}, 1);
        check_val("abort_flags", {28'h0, flags}, 4'b0001);
        check_val("abort_done", {31'h0, done}, 0);
        check_val("abort_opcode", {16'h0, bus.alu_opcode}, 0);
        check_reg("abort_r1", 4'd1, 16'h0);
        check_reg("abort_r3", 4'd3, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check_val("abort_no_done", dn, 0);
        check_reg("abort_r8", 4'd8, 16'h0);

        // immediate op: R5 = R1 + 7
        ext_load(4'd1, 16'd10);
        ext_load(4'd5, 16'h0055);
        run_instr(16'h2000, 12'h517, lat, low, a_s, b_s);
        check_val("imm_latency", lat, 3);
`ifdef ALU_SEQ_IMMEDIATE_EN
        check_val("imm_alu_b", {16'h0, b_s}, 7);
        check_reg("imm_r5", 4'd5, 16'd17);
        check_val("imm_flags", {28'h0, flags}, 4'b0000);
`else
        check_reg("imm_r5", 4'd5, 16'h0055);
        check_val("imm_flags", {28'h0, flags}, 4'b0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
